// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the five-stage pipeline controller.
//   - stall vector bit positions and the two stall patterns the controller emits
//   - controller FSM state encoding
//   - 2-bit branch-history counter type and its saturating update
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int ST_PC  = 0;
  localparam int ST_IF  = 1;
  localparam int ST_ID  = 2;
  localparam int ST_EX  = 3;
  localparam int ST_MEM = 4;
  localparam int ST_WB  = 5;

  localparam logic [STALL_W-1:0] STALL_NONE = '0;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;  // everything up to MEM frozen
  localparam logic [STALL_W-1:0] STALL_LU   = 6'b000111;  // PC/IF/ID frozen, bubble into EX

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef logic [1:0] ctr2_t;
  localparam ctr2_t SNT = 2'b00;
  localparam ctr2_t WNT = 2'b01;
  localparam ctr2_t WT  = 2'b10;
  localparam ctr2_t STK = 2'b11;

  function automatic ctr2_t ctr2_next(ctr2_t c, logic taken);
    if (taken) return (c == STK) ? c : ctr2_t'(c + 2'b01);
    else       return (c == SNT) ? c : ctr2_t'(c - 2'b01);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-controller bus between the pipeline stages and
// the controller.
//   master: pipeline side (drives stall requests, branch resolution, mem_busy;
//           receives stall/flush/redirect, prediction and status)
//   slave : controller side
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              id_stall_load;
  logic              id_stall_store;
  logic [31:0]       id_pc;
  logic              predict_o;
  logic              ex_br_valid;
  logic [31:0]       ex_pc;
  logic              ex_taken;
  logic              ex_predicted;
  logic [31:0]       ex_target;
  logic              mem_busy;
  logic [5:0]        stall;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  br_cnt;
  logic [CNT_W-1:0]  mis_cnt;
  logic              timeout_err;

  modport master (
    output id_stall_load, id_stall_store, id_pc,
    output ex_br_valid, ex_pc, ex_taken, ex_predicted, ex_target, mem_busy,
    input  predict_o, stall, flush_if_id, flush_id_ex, redirect, redirect_pc,
    input  br_cnt, mis_cnt, timeout_err
  );

  modport slave (
    input  id_stall_load, id_stall_store, id_pc,
    input  ex_br_valid, ex_pc, ex_taken, ex_predicted, ex_target, mem_busy,
    output predict_o, stall, flush_if_id, flush_id_ex, redirect, redirect_pc,
    output br_cnt, mis_cnt, timeout_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl_bht.sv
// branch_history_table: array of 2-bit saturating counters.
//   rd_idx/rd_ctr : combinational read port (returns pre-update value on a
//                   same-cycle read/write collision)
//   wr_en/wr_idx/wr_taken : registered update port
//   rst : synchronous, sets every entry to weakly-not-taken
module branch_history_table
  import pipe_ctrl_pkg::*;
#(
  parameter int ENTRIES = 16,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output ctr2_t            rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  ctr2_t tbl [ENTRIES];

  assign rd_ctr = tbl[rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= WNT;
    end else if (wr_en) begin
      tbl[wr_idx] <= ctr2_next(tbl[wr_idx], wr_taken);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush/redirect controller for the 5-stage core.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : ID stall requests and PC, EX branch resolution, mem_busy in;
//                  per-stage stall vector, flushes, redirect, BHT prediction,
//                  branch/mispredict counters and watchdog flag out
// Priority: mem_busy > mispredict > ID load/store stall.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int BHT_ENTRIES = 16,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int IDX    = $clog2(BHT_ENTRIES);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic               resolved, mispred;
  ctr2_t              rd_ctr;
  logic [STALL_W-1:0] stall_c;
  logic               flush_if_id_c, flush_id_ex_c, redirect_c;
  logic [31:0]        redirect_pc_c;
  logic [CNT_W-1:0]   br_cnt_q, mis_cnt_q;
  logic [WAIT_W-1:0]  wait_q, wait_inc;
  logic               timeout_q;
  logic               unused_bits;

  // A branch held in EX by mem_busy is not resolved until the stall lifts,
  // so it updates the BHT and the counters exactly once.
  assign resolved = bus.ex_br_valid && !bus.mem_busy;
  assign mispred  = resolved && (bus.ex_taken != bus.ex_predicted);

  branch_history_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (bus.id_pc[IDX+1:2]),
    .rd_ctr   (rd_ctr),
    .wr_en    (resolved),
    .wr_idx   (bus.ex_pc[IDX+1:2]),
    .wr_taken (bus.ex_taken)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (bus.mem_busy)  state_d = MEM_WAIT;
      MEM_WAIT: if (!bus.mem_busy) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // FSM outputs: combinational pipeline commands, forced quiet during reset
  always_comb begin
    stall_c       = STALL_NONE;
    flush_if_id_c = 1'b0;
    flush_id_ex_c = 1'b0;
    redirect_c    = 1'b0;
    redirect_pc_c = '0;
    if (!rst) begin
      if (bus.mem_busy) begin
        stall_c = STALL_MEM;
      end else if (mispred) begin
        // The flushed ID instruction makes any ID stall request moot.
        flush_if_id_c = 1'b1;
        flush_id_ex_c = 1'b1;
        redirect_c    = 1'b1;
        redirect_pc_c = bus.ex_taken ? bus.ex_target : bus.ex_pc + 32'd4;
      end else if (bus.id_stall_load || bus.id_stall_store) begin
        stall_c       = STALL_LU;
        flush_id_ex_c = 1'b1;
      end
    end
  end

  // Performance counters, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (resolved && (br_cnt_q != '1))  br_cnt_q  <= br_cnt_q + CNT_W'(1);
      if (mispred  && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  // Watchdog: the count includes the cycle that enters MEM_WAIT, so the flag
  // is visible the cycle after the MEM_TIMEOUT-th consecutive busy cycle.
  assign wait_inc = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else if (state_d == MEM_WAIT) begin
      wait_q <= wait_inc;
      if (wait_inc == WAIT_MAX) timeout_q <= 1'b1;
    end else begin
      wait_q <= '0;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.flush_if_id = flush_if_id_c;
  assign bus.flush_id_ex = flush_id_ex_c;
  assign bus.redirect    = redirect_c;
  assign bus.redirect_pc = redirect_pc_c;
  assign bus.predict_o   = !rst && rd_ctr[1];
  assign bus.br_cnt      = br_cnt_q;
  assign bus.mis_cnt     = mis_cnt_q;
  assign bus.timeout_err = timeout_q;

  // PC bits outside the BHT index and the counter LSB are intentionally unused.
  assign unused_bits = ^{bus.id_pc[31:IDX+2], bus.id_pc[1:0],
                         bus.ex_pc[31:IDX+2], bus.ex_pc[1:0], rd_ctr[0]};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int CW = 4;
  localparam int TO = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.BHT_ENTRIES(16), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ld, st, brv, tk, pr, mb;
    logic [31:0] idpc, expc, extgt;
    logic [5:0]  stall;
    bit          fie, fix, red;
    logic [31:0] rpc;
  } vec_t;

  typedef struct {
    logic [5:0]    stall;
    bit            fie, fix, red;
    logic [31:0]   rpc;
    bit            pred;
    logic [CW-1:0] br, mis;
    bit            err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // reference model of the registered state
  bit [1:0] m_bht [16];
  int       m_br, m_mis, m_wait;
  bit       m_err;

  function automatic vec_t mk(bit ld, bit st, bit brv, bit tk, bit pr, bit mb,
                              logic [31:0] idpc, logic [31:0] expc, logic [31:0] extgt,
                              logic [5:0] stall, bit fie, bit fix, bit red,
                              logic [31:0] rpc);
    vec_t v;
    v.ld = ld; v.st = st; v.brv = brv; v.tk = tk; v.pr = pr; v.mb = mb;
    v.idpc = idpc; v.expc = expc; v.extgt = extgt;
    v.stall = stall; v.fie = fie; v.fix = fix; v.red = red; v.rpc = rpc;
    return v;
  endfunction

  function automatic vec_t idle(logic [31:0] idpc);
    return mk(0,0,0,0,0,0, idpc, 32'h0, 32'h0, 6'b000000, 0,0,0, 32'h0);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    m_br = 0; m_mis = 0; m_wait = 0; m_err = 0;
  endtask

  task automatic model_step(vec_t v);
    int idx;
    if (v.brv && !v.mb) begin
      idx = int'(v.expc[5:2]);
      if (v.tk  && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'b01;
      if (!v.tk && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'b01;
      if (m_br < CMAX) m_br++;
      if (v.tk != v.pr && m_mis < CMAX) m_mis++;
    end
    if (v.mb) begin
      m_wait++;
      if (m_wait >= TO) m_err = 1;
    end else begin
      m_wait = 0;
    end
  endtask

  // Called just after a posedge; drives, scores at negedge, advances model.
  task automatic apply(vec_t v);
    exp_t e, g;
    bus.id_stall_load  = v.ld;
    bus.id_stall_store = v.st;
    bus.id_pc          = v.idpc;
    bus.ex_br_valid    = v.brv;
    bus.ex_pc          = v.expc;
    bus.ex_taken       = v.tk;
    bus.ex_predicted   = v.pr;
    bus.ex_target      = v.extgt;
    bus.mem_busy       = v.mb;
    e.stall = v.stall; e.fie = v.fie; e.fix = v.fix; e.red = v.red; e.rpc = v.rpc;
    e.pred  = m_bht[int'(v.idpc[5:2])][1];
    e.br    = CW'(m_br);
    e.mis   = CW'(m_mis);
    e.err   = m_err;
    sb.push_back(e);
    @(negedge clk);
    g = sb.pop_front();
    chk("stall",       32'(bus.stall),       32'(g.stall));
    chk("flush_if_id", 32'(bus.flush_if_id), 32'(g.fie));
    chk("flush_id_ex", 32'(bus.flush_id_ex), 32'(g.fix));
    chk("redirect",    32'(bus.redirect),    32'(g.red));
    chk("redirect_pc", bus.redirect_pc,      g.rpc);
    chk("predict_o",   32'(bus.predict_o),   32'(g.pred));
    chk("br_cnt",      32'(bus.br_cnt),      32'(g.br));
    chk("mis_cnt",     32'(bus.mis_cnt),     32'(g.mis));
    chk("timeout_err", 32'(bus.timeout_err), 32'(g.err));
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  // Reset asserted in the middle of a memory stall with a mispredict and
  // ID stall pending: every combinational command must be quiet.
  task automatic do_reset();
    rst = 1'b1;
    bus.mem_busy = 1'b1; bus.id_stall_load = 1'b1; bus.id_stall_store = 1'b0;
    bus.ex_br_valid = 1'b1; bus.ex_taken = 1'b1; bus.ex_predicted = 1'b0;
    bus.ex_pc = 32'h40; bus.ex_target = 32'h80; bus.id_pc = 32'h40;
    @(negedge clk);
    chk("rst stall",       32'(bus.stall),       32'h0);
    chk("rst flush_if_id", 32'(bus.flush_if_id), 32'h0);
    chk("rst flush_id_ex", 32'(bus.flush_id_ex), 32'h0);
    chk("rst redirect",    32'(bus.redirect),    32'h0);
    chk("rst redirect_pc", bus.redirect_pc,      32'h0);
    chk("rst predict_o",   32'(bus.predict_o),   32'h0);
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl [10];
  int   b0;

  initial begin
    rst = 1'b1;
    bus.id_stall_load = 0; bus.id_stall_store = 0; bus.id_pc = '0;
    bus.ex_br_valid = 0; bus.ex_pc = '0; bus.ex_taken = 0; bus.ex_predicted = 0;
    bus.ex_target = '0; bus.mem_busy = 0;
    @(posedge clk); #1;
    do_reset();

    // prediction after reset, then train 0x40 taken twice
    apply(idle(32'h40));
    repeat (2) apply(mk(0,0,1,1,0,0, 32'h40, 32'h40, 32'h80, 6'b000000, 1,1,1, 32'h80));
    apply(idle(32'h40));
    chk("trained predict_o", 32'(bus.predict_o), 32'h1);
    chk("trained br_cnt",    32'(bus.br_cnt),    32'd2);
    chk("trained mis_cnt",   32'(bus.mis_cnt),   32'd2);

    // load-use stall for one cycle, released the next
    apply(mk(1,0,0,0,0,0, 32'h44, 32'h0, 32'h0, 6'b000111, 0,1,0, 32'h0));
    apply(idle(32'h48));

    // not-taken mispredict overrides a coincident store stall
    apply(mk(0,1,1,0,1,0, 32'h48, 32'h100, 32'h300, 6'b000000, 1,1,1, 32'h104));

    // priority and boundary vectors
    tbl[0] = mk(1,0,1,1,0,1, 32'h50, 32'h40, 32'h80, 6'b011111, 0,0,0, 32'h0);
    tbl[1] = idle(32'h54);
    tbl[2] = mk(1,1,0,0,0,0, 32'h58, 32'h0, 32'h0, 6'b000111, 0,1,0, 32'h0);
    tbl[3] = mk(0,1,0,0,0,0, 32'h5c, 32'h0, 32'h0, 6'b000111, 0,1,0, 32'h0);
    tbl[4] = mk(0,0,1,1,1,0, 32'h60, 32'h80, 32'h10, 6'b000000, 0,0,0, 32'h0);
    tbl[5] = mk(1,0,1,0,0,0, 32'h64, 32'h84, 32'h10, 6'b000111, 0,1,0, 32'h0);
    tbl[6] = mk(0,0,1,0,1,0, 32'h68, 32'hFFFFFFFC, 32'h10, 6'b000000, 1,1,1, 32'h0);
    tbl[7] = mk(0,0,1,1,0,0, 32'h6c, 32'hFFFFFFFC, 32'h1000, 6'b000000, 1,1,1, 32'h1000);
    tbl[8] = idle(32'hFFFFFFFC);
    tbl[9] = idle(32'h100);
    for (int i = 0; i < 10; i++) apply(tbl[i]);

    // taken mispredict held behind a 3-cycle memory stall
    b0 = m_br;
    repeat (3) apply(mk(0,0,1,1,0,1, 32'h70, 32'h1F0, 32'h200, 6'b011111, 0,0,0, 32'h0));
    apply(mk(0,0,1,1,0,0, 32'h70, 32'h1F0, 32'h200, 6'b000000, 1,1,1, 32'h200));
    apply(idle(32'h74));
    chk("deferred br_cnt once", 32'(bus.br_cnt), 32'(b0 + 1));

    // watchdog: flag appears after the 4th consecutive busy cycle
    for (int i = 1; i <= 6; i++) begin
      apply(mk(0,0,0,0,0,1, 32'h80, 32'h0, 32'h0, 6'b011111, 0,0,0, 32'h0));
      if (i == TO - 1) chk("timeout before limit", 32'(bus.timeout_err), 32'h0);
      if (i == TO)     chk("timeout at limit",     32'(bus.timeout_err), 32'h1);
    end
    repeat (2) apply(idle(32'h84));
    chk("timeout sticky", 32'(bus.timeout_err), 32'h1);
    do_reset();
    apply(idle(32'h40));
    chk("timeout cleared", 32'(bus.timeout_err), 32'h0);
    chk("br_cnt cleared",  32'(bus.br_cnt),      32'h0);

    // counter saturation
    repeat (17) apply(mk(0,0,1,1,0,0, 32'h40, 32'h40, 32'h80, 6'b000000, 1,1,1, 32'h80));
    apply(idle(32'h40));
    chk("mis_cnt saturated", 32'(bus.mis_cnt), 32'd15);
    chk("br_cnt saturated",  32'(bus.br_cnt),  32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time limit: got running, expected finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline controller for the five-stage RISC-V core (IF/ID/EX/MEM/WB). It turns the ID-stage load/store stall requests, the EX-stage branch resolution and the data-memory busy signal into one per-stage stall vector plus flush and redirect commands. It holds the 2-bit branch history table that drives ID's `Predict` input, and it keeps branch/mispredict performance counters and a memory-wait watchdog.

## Interface
- `BHT_ENTRIES`, 16: number of 2-bit counters; power of two, 2..256.
- `MEM_TIMEOUT`, 255: consecutive `mem_busy` cycles allowed before `timeout_err` is set.
- `CNT_W`, 16: width of the performance counters.

- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_stall_load` in 1: load-use stall request from ID (`StallReqLoad`).
- `id_stall_store` in 1: store stall request from ID (`StallReqStore`).
- `id_pc` in 32: PC of the instruction in ID.
- `predict_o` out 1: prediction for the branch in ID; goes to ID `Predict`.
- `ex_br_valid` in 1: conditional branch (beq/blt) resolving in EX this cycle.
- `ex_pc` in 32: PC of the resolving branch.
- `ex_taken` in 1: actual branch outcome.
- `ex_predicted` in 1: the `PredictFlag` carried with the branch.
- `ex_target` in 32: taken target of the branch.
- `mem_busy` in 1: data memory not ready.
- `stall` out 6: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
- `flush_if_id` out 1: replace the IF/ID latch contents with a NOP.
- `flush_id_ex` out 1: replace the ID/EX latch contents with a bubble.
- `redirect` out 1: IF loads `redirect_pc`.
- `redirect_pc` out 32: correct fetch address.
- `br_cnt` out CNT_W: number of resolved branches.
- `mis_cnt` out CNT_W: number of mispredicts.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- FSM states:
  - RUN: the normal state.
  - MEM_WAIT: entered on `mem_busy` = 1; returns to RUN on the first cycle with `mem_busy` = 0.
- Mispredict condition, `mispred`: `ex_br_valid && (ex_taken != ex_predicted) && !mem_busy`.
- Output priority, highest first:
  1. `mem_busy`: `stall` = 6'b011111, all other commands 0. EX is held, so a pending branch resolves later, exactly once.
  2. `mispred`: `stall` = 0; `flush_if_id` = `flush_id_ex` = `redirect` = 1; `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc`+4 (modulo 2^32). Any coincident ID stall request is ignored, because the flush removes that instruction.
  3. `id_stall_load` | `id_stall_store`: `stall` = 6'b000111, `flush_id_ex` = 1.
  4. Otherwise all commands are 0 and `redirect_pc` = 0.
- BHT:
  - Index = `pc[IDX+1:2]`, with IDX = log2(BHT_ENTRIES).
  - `predict_o` = MSB of the entry indexed by `id_pc`.
  - On a resolved branch (`ex_br_valid && !mem_busy`), the entry indexed by `ex_pc` does a saturating increment if taken, decrement if not (00..11).
  - A same-cycle read and write to one entry returns the old value.
- Counters:
  - `br_cnt` increments on each resolved branch.
  - `mis_cnt` increments on each `mispred`.
  - Both saturate at all-ones.
- Watchdog:
  - The wait counter counts consecutive MEM_WAIT cycles and clears in RUN.
  - `timeout_err` sets when the count reaches `MEM_TIMEOUT` and stays set until `rst`.

## Timing
- `stall`, `flush_*`, `redirect` and `redirect_pc` are combinational, valid in the same cycle as their inputs.
- BHT, counter, watchdog and FSM updates are registered at the next posedge.
- A BHT update is visible on `predict_o` from the cycle after resolution.
- Reset (synchronous, takes effect even mid-stall):
  - Every output is 0, including `predict_o`.
  - The FSM goes to RUN; the counters and watchdog clear.
  - All BHT entries are set to 2'b01 (weakly not-taken).
- A `mem_busy` arriving together with a mispredict defers the redirect, the BHT update and the counters until `mem_busy` drops.

## Structure
- `pipe_ctrl_pkg` holds:
  - stall bit-index constants and the stall patterns (STALL_MEM = 6'b011111, STALL_LU = 6'b000111);
  - the FSM state enum;
  - the 2-bit counter type with WNT = 2'b01.
- Sub-module `branch_history_table`: 1 combinational read port, 1 registered update port, synchronous reset initialisation.

## Test plan
- Reset, then `id_pc` = 0x40 → `predict_o` = 0. Resolve 0x40 taken twice (predicted 0) → `mis_cnt` = 2, `br_cnt` = 2, `predict_o` = 1 at `id_pc` 0x40.
- `id_stall_load` = 1 for 1 cycle → `stall` = 6'b000111, `flush_id_ex` = 1; the next cycle `stall` = 0.
- Mispredict with `ex_pc` = 0x100, `ex_taken` = 0, `ex_predicted` = 1, plus `id_stall_store` = 1 → `redirect_pc` = 0x104, both flushes = 1, `stall` = 0.
- `mem_busy` = 1 for 3 cycles with a taken mispredicting branch to 0x200 held in EX → `stall` = 6'b011111 and `redirect` = 0 for those 3 cycles; the next cycle `redirect` = 1, `redirect_pc` = 0x200; `br_cnt` increments once.
- `MEM_TIMEOUT` = 4, `mem_busy` held for 6 cycles → `timeout_err` = 1 from the cycle after the 4th busy cycle; it stays 1 after `mem_busy` drops; `rst` clears it.
- `CNT_W` = 4, 17 mispredicts → `mis_cnt` = 15 (saturated).
